boot_sequencer: RTL and testbench

Controller that owns the CPU's reset and the instruction ROM write port. After power-up it holds the CPU in reset, streams a program image into instruction memory over a valid/ready word stream, then releases the CPU to execute from address 0. A halt request returns the CPU to reset so a new image can be loaded without a power cycle.

---
 rtl/boot_sequencer.sv | 131 +++++++++++++
 tb/tb_boot_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/boot_sequencer.sv
// boot_sequencer: holds the CPU in reset, streams a program image into instruction ROM, then releases the CPU.
// Define BOOT_TIMEOUT_EN to abort loads that stall for TIMEOUT cycles and raise the sticky err flag.
module boot_sequencer #(
  parameter int ROM_AW = 15,
  parameter int TIMEOUT = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ROM_AW-1:0] load_len,
  input  logic              s_valid,
  input  logic [15:0]       s_data,
  output logic              s_ready,
  output logic              rom_we,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [15:0]       rom_wdata,
  output logic              cpu_reset,
  input  logic              halt_req,
  output logic              running,
  output logic              done,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, LOAD, RELEASE, RUN} state_t;
  state_t state, stateNext;
  logic [ROM_AW-1:0] wordCnt, wordCntNext, loadLen, loadLenNext, romAddrNext;
  logic [15:0] romWdataNext;
  logic romWeNext, cpuResetNext, runningNext, doneNext, handshake;
  if (TIMEOUT < 1) begin : gBadTimeout
    $error("TIMEOUT must be at least 1");
  end
`ifdef BOOT_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT - 1);
  logic [SW-1:0] stallCnt, stallCntNext;
  logic errNext;
`else
  assign err = 1'b0;
`endif
  assign s_ready = state == LOAD;
  assign handshake = s_ready && s_valid;
  always_comb begin
    stateNext = state;
    wordCntNext = wordCnt;
    loadLenNext = loadLen;
    romWeNext = 1'b0;
    romAddrNext = rom_addr;
    romWdataNext = rom_wdata;
    cpuResetNext = cpu_reset;
    runningNext = running;
    doneNext = 1'b0;
`ifdef BOOT_TIMEOUT_EN
    stallCntNext = stallCnt;
    errNext = err;
`endif
    case (state)
      IDLE: begin
        cpuResetNext = 1'b1;
        if (load_start) begin
          stateNext = (load_len != '0) ? LOAD : RELEASE;
          loadLenNext = load_len;
          wordCntNext = '0;
`ifdef BOOT_TIMEOUT_EN
          stallCntNext = '0;
          errNext = 1'b0;
`endif
        end
      end
      // Exit on the last word so the counter never has to wrap.
      LOAD: if (handshake) begin
        romWeNext = 1'b1;
        romAddrNext = wordCnt;
        romWdataNext = s_data;
        wordCntNext = wordCnt + 1'b1;
        stateNext = (wordCnt == loadLen - 1'b1) ? RELEASE : LOAD;
`ifdef BOOT_TIMEOUT_EN
        stallCntNext = '0;
`endif
      end
`ifdef BOOT_TIMEOUT_EN
      else if (stallCnt == STALL_LAST) begin
        stateNext = IDLE;
        errNext = 1'b1;
        stallCntNext = '0;
      end else stallCntNext = stallCnt + 1'b1;
`endif
      RELEASE: begin
        stateNext = RUN;
        cpuResetNext = 1'b0;
        runningNext = 1'b1;
        doneNext = 1'b1;
      end
      RUN: if (halt_req) begin
        stateNext = IDLE;
        cpuResetNext = 1'b1;
        runningNext = 1'b0;
      end
      default: stateNext = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      wordCnt <= '0;
      loadLen <= '0;
      rom_we <= 1'b0;
      rom_addr <= '0;
      rom_wdata <= '0;
      cpu_reset <= 1'b1;
      running <= 1'b0;
      done <= 1'b0;
`ifdef BOOT_TIMEOUT_EN
      stallCnt <= '0;
      err <= 1'b0;
`endif
    end else begin
      state <= stateNext;
      wordCnt <= wordCntNext;
      loadLen <= loadLenNext;
      rom_we <= romWeNext;
      rom_addr <= romAddrNext;
      rom_wdata <= romWdataNext;
      cpu_reset <= cpuResetNext;
      running <= runningNext;
      done <= doneNext;
`ifdef BOOT_TIMEOUT_EN
      stallCnt <= stallCntNext;
      err <= errNext;
`endif
    end
  end
endmodule

// File: tb/tb_boot_sequencer.sv
// tb_boot_sequencer: directed test-plan scenarios plus randomized traffic against a behavioural model of the loader.
module tb_boot_sequencer;
  localparam int AW = 4;
  localparam int TO = 8;
  logic clock = 0, reset = 0, load_start = 0, s_valid = 0, halt_req = 0;
  logic [AW-1:0] load_len = '0;
  logic [15:0] s_data = '0;
  logic s_ready, rom_we, cpu_reset, running, done, err;
  logic [AW-1:0] rom_addr;
  logic [15:0] rom_wdata;
  int checks = 0, errors = 0;
  typedef enum {M_IDLE, M_LOAD, M_RELEASE, M_RUN} phase_t;
  phase_t phase;
  int remaining, nextAddr, stall, eAddr;
  logic eWe, eCpuReset, eRunning, eDone, eErr;
  logic [15:0] eData;
  logic [15:0] mem [2**AW];
  logic [15:0] image [$];
  logic [15:0] words [3] = '{16'h0010, 16'hEC10, 16'hE308};
  always #5 clock = ~clock;
  boot_sequencer #(.ROM_AW(AW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .load_start(load_start), .load_len(load_len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .rom_we(rom_we),
    .rom_addr(rom_addr), .rom_wdata(rom_wdata), .cpu_reset(cpu_reset),
    .halt_req(halt_req), .running(running), .done(done), .err(err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic modelReset();
    phase = M_IDLE;
    eWe = 0; eAddr = 0; eData = '0; eCpuReset = 1; eRunning = 0; eDone = 0; eErr = 0;
    image.delete();
  endtask
  task automatic modelEdge(output bit enteredRun);
    enteredRun = 0;
    eWe = 0;
    eDone = 0;
    case (phase)
      M_IDLE: if (load_start) begin
        eErr = 0;
        image.delete();
        if (load_len != 0) begin
          phase = M_LOAD; remaining = int'(load_len); nextAddr = 0; stall = 0;
        end else phase = M_RELEASE;
      end
      M_LOAD: if (s_valid) begin
        eWe = 1; eAddr = nextAddr; eData = s_data;
        image.push_back(s_data);
        nextAddr++; remaining--; stall = 0;
        if (remaining == 0) phase = M_RELEASE;
      end else begin
`ifdef BOOT_TIMEOUT_EN
        stall++;
        if (stall == TO) begin phase = M_IDLE; eErr = 1; end
`endif
      end
      M_RELEASE: begin
        phase = M_RUN; eCpuReset = 0; eRunning = 1; eDone = 1; enteredRun = 1;
      end
      M_RUN: if (halt_req) begin phase = M_IDLE; eCpuReset = 1; eRunning = 0; end
    endcase
  endtask
  task automatic checkOutputs();
    check("s_ready", s_ready, phase == M_LOAD);
    check("rom_we", rom_we, eWe);
    check("rom_addr", rom_addr, eAddr);
    check("rom_wdata", rom_wdata, eData);
    check("cpu_reset", cpu_reset, eCpuReset);
    check("running", running, eRunning);
    check("done", done, eDone);
    check("err", err, eErr);
  endtask
  task automatic step();
    bit entered;
    @(posedge clock);
    modelEdge(entered);
    #1;
    checkOutputs();
    if (rom_we === 1'b1) mem[rom_addr] = rom_wdata;
    if (entered) for (int i = 0; i < image.size(); i++) check("rom_image", mem[i], image[i]);
    @(negedge clock);
  endtask
  task automatic drive(input bit ls, input int len, input bit sv, input logic [15:0] sd, input bit hr);
    load_start = ls; load_len = AW'(len); s_valid = sv; s_data = sd; halt_req = hr;
  endtask
  task automatic asyncReset();
    #2 reset = 0;
    #1 modelReset();
    checkOutputs();
    @(negedge clock);
    reset = 1;
  endtask
  task automatic loadImage(input int len, input bit bubbles);
    drive(1, len, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 4 * len + 4 && phase == M_LOAD; i++) begin
      s_valid = bubbles ? (i % 2 == 0) : 1'b1;
      s_data = 16'($urandom);
      step();
    end
    drive(0, 0, 0, 0, 0);
    repeat (3) step();
  endtask
  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;
    modelReset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutputs();
    reset = 1;
    drive(1, 3, 0, 0, 0); step();
    for (int i = 0; i < 3; i++) begin drive(0, 0, 1, words[i], 0); step(); end
    drive(0, 0, 0, 0, 0); repeat (3) step();
    drive(0, 0, 0, 0, 1); step();
    drive(0, 0, 0, 0, 0); step();
    loadImage(4, 1);
    drive(0, 0, 0, 0, 1); step();
    drive(1, 0, 0, 0, 0); repeat (4) step();
    drive(1, 2, 0, 0, 0); step();
    drive(0, 0, 0, 0, 1); step();
    loadImage(1, 0);
    drive(0, 0, 0, 0, 1); step();
    drive(1, 5, 0, 0, 0); step();
    for (int i = 0; i < 2; i++) begin drive(0, 0, 1, 16'($urandom), 0); step(); end
    asyncReset();
    loadImage(15, 0);
    drive(0, 0, 0, 0, 1); step();
    drive(1, 2, 0, 0, 0); step();
    drive(0, 0, 1, 16'h1234, 0); step();
    drive(0, 0, 0, 0, 0); repeat (TO + 3) step();
    drive(1, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0); repeat (2) step();
    for (int c = 0; c < 3000; c++) begin
      load_start = $urandom_range(0, 7) == 0;
      case ($urandom_range(0, 9))
        0: load_len = '0;
        1: load_len = AW'(2**AW - 1);
        default: load_len = AW'($urandom_range(1, 6));
      endcase
      s_valid = $urandom_range(0, 9) < 7;
      s_data = 16'($urandom);
      halt_req = $urandom_range(0, 5) == 0;
      if ($urandom_range(0, 399) == 0) asyncReset();
      else step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
